i2c_burst_master: RTL and testbench

I2C_BURST_MASTER -- requirements
Module: i2c_burst_master

---
 rtl/my_pkg.sv | 29 ++
 rtl/i2c_scl_gen.sv | 52 +++++
 rtl/i2c_burst_master.sv | 182 ++++++++++++++++++
 tb/tb_i2c_burst_master.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/my_pkg.sv
// Shared definitions for the I2C burst master.
//   state_t   : transfer-level FSM states
//   quarter_t : SCL quarter-phase within one bit-time (Q0/Q1 SCL low, Q2/Q3 SCL high)
//   CLK_DIV_DEF / MAX_BYTES_DEF : default parameter values
package my_pkg;

  localparam int CLK_DIV_DEF   = 4;
  localparam int MAX_BYTES_DEF = 4;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    STOP
  } state_t;

  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } quarter_t;

endpackage

// File: rtl/i2c_scl_gen.sv
// Quarter-phase timebase for the I2C burst master.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   run          : 1 while a transfer is active; 0 parks the counter at Q0/cnt 0
//   hold         : freezes the counter (clock stretching); ignored when run=0
//   phase        : current quarter-phase
//   sample       : last cycle of Q2 (the cycle in which SDA is sampled)
//   bit_end      : last cycle of Q3 (the bit-time ends on the next edge)
import my_pkg::*;

module i2c_scl_gen #(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     run,
  input  logic     hold,
  output quarter_t phase,
  output logic     sample,
  output logic     bit_end
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          q_end;

  // A held counter never ends its quarter, so sampling and bit boundaries
  // slide out by exactly the number of held cycles.
  assign q_end   = run && !hold && (cnt == LAST);
  assign sample  = q_end && (phase == Q2);
  assign bit_end = q_end && (phase == Q3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= Q0;
    end else if (!run) begin
      cnt   <= '0;
      phase <= Q0;
    end else if (!hold) begin
      if (cnt == LAST) begin
        cnt   <= '0;
        phase <= quarter_t'(phase + 2'd1);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_burst_master.sv
// I2C burst master: START, 7-bit address + R/W, 1..MAX_BYTES data bytes, STOP.
// Ports:
//   clk, reset_n               : clock, asynchronous active-low reset
//   Master_en                  : one-cycle start request (ignored while busy)
//   R_W_en, Mem_Addr, byte_len : transfer descriptor, sampled with Master_en
//   tx_req / tx_data           : tx_req pulses one cycle; tx_data is taken in that
//                                same cycle (no backpressure, data must be valid then)
//   data_out / rx_valid        : last read byte, rx_valid pulses when it updates
//   busy, done, nack           : in progress / end pulse / sticky slave NACK
//   scl, sda_out, sda_oe       : bus outputs; sda_in is the sampled SDA level
//   scl_in                     : only with I2C_CLK_STRETCH_EN; SCL bus level, a low
//                                level during Q2 stretches the bit
// Build option: define I2C_CLK_STRETCH_EN to add scl_in and clock stretching.
import my_pkg::*;

module i2c_burst_master #(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int MAX_BYTES = MAX_BYTES_DEF
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           Master_en,
  input  logic                           R_W_en,
  input  logic [6:0]                     Mem_Addr,
  input  logic [$clog2(MAX_BYTES+1)-1:0] byte_len,
  input  logic [7:0]                     tx_data,
  output logic                           tx_req,
  output logic [7:0]                     data_out,
  output logic                           rx_valid,
  output logic                           busy,
  output logic                           done,
  output logic                           nack,
  output logic                           scl,
  output logic                           sda_out,
  output logic                           sda_oe,
`ifdef I2C_CLK_STRETCH_EN
  input  logic                           scl_in,
`endif
  input  logic                           sda_in
);

  localparam int LW = $clog2(MAX_BYTES + 1);

  state_t         state, state_nxt;
  quarter_t       phase;
  logic           sample, bit_end, hold, len_ok, last;
  logic [7:0]     addr_byte, wr_sh, rx_sh;
  logic           rw_q;
  logic [LW-1:0]  bytes_left;
  logic [2:0]     bit_cnt;

`ifdef I2C_CLK_STRETCH_EN
  assign hold = (phase == Q2) && !scl_in;
`else
  assign hold = 1'b0;
`endif

  i2c_scl_gen #(.CLK_DIV(CLK_DIV)) u_scl_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (state != IDLE),
    .hold    (hold),
    .phase   (phase),
    .sample  (sample),
    .bit_end (bit_end)
  );

  assign len_ok = (byte_len != '0) && (byte_len <= LW'(MAX_BYTES));
  assign last   = (bytes_left == LW'(1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (Master_en && len_ok) state_nxt = START;
      START:    if (bit_end) state_nxt = ADDR;
      ADDR:     if (bit_end && bit_cnt == 3'd7) state_nxt = ADDR_ACK;
      ADDR_ACK: if (bit_end) state_nxt = nack ? STOP : (rw_q ? RD_BYTE : WR_BYTE);
      WR_BYTE:  if (bit_end && bit_cnt == 3'd7) state_nxt = WR_ACK;
      WR_ACK:   if (bit_end) state_nxt = (nack || last) ? STOP : WR_BYTE;
      RD_BYTE:  if (bit_end && bit_cnt == 3'd7) state_nxt = RD_ACK;
      RD_ACK:   if (bit_end) state_nxt = last ? STOP : RD_BYTE;
      STOP:     if (bit_end) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output logic. START keeps SCL high for the whole bit and drops SDA at
  // Q2; STOP holds SDA low through Q2 and raises it at Q3, both with SCL high.
  always_comb begin
    scl     = 1'b1;
    sda_out = 1'b1;
    sda_oe  = 1'b0;
    busy    = (state != IDLE);
    tx_req  = bit_end && !nack &&
              (((state == ADDR_ACK) && !rw_q) || ((state == WR_ACK) && !last));
    case (state)
      START: begin
        sda_oe  = 1'b1;
        sda_out = (phase == Q0) || (phase == Q1);
      end
      ADDR: begin
        scl     = (phase == Q2) || (phase == Q3);
        sda_oe  = 1'b1;
        sda_out = addr_byte[3'd7 - bit_cnt];
      end
      WR_BYTE: begin
        scl     = (phase == Q2) || (phase == Q3);
        sda_oe  = 1'b1;
        sda_out = wr_sh[3'd7 - bit_cnt];
      end
      ADDR_ACK, WR_ACK, RD_BYTE: begin
        scl = (phase == Q2) || (phase == Q3);
      end
      RD_ACK: begin
        scl     = (phase == Q2) || (phase == Q3);
        sda_oe  = 1'b1;
        sda_out = last;
      end
      STOP: begin
        scl     = (phase == Q2) || (phase == Q3);
        sda_oe  = 1'b1;
        sda_out = (phase == Q3);
      end
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_byte  <= '0;
      rw_q       <= 1'b0;
      bytes_left <= '0;
      bit_cnt    <= '0;
      wr_sh      <= '0;
      rx_sh      <= '0;
      data_out   <= 8'h00;
      rx_valid   <= 1'b0;
      done       <= 1'b0;
      nack       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      done     <= 1'b0;
      if (state == IDLE && Master_en) begin
        if (len_ok) begin
          addr_byte  <= {Mem_Addr, R_W_en};
          rw_q       <= R_W_en;
          bytes_left <= byte_len;
          bit_cnt    <= '0;
          nack       <= 1'b0;
        end else begin
          done <= 1'b1;
        end
      end
      if (tx_req) wr_sh <= tx_data;
      // bit_cnt wraps 7 -> 0 on its own, ready for the next byte
      if (bit_end && (state == ADDR || state == WR_BYTE || state == RD_BYTE))
        bit_cnt <= bit_cnt + 3'd1;
      if (sample && (state == ADDR_ACK || state == WR_ACK) && sda_in)
        nack <= 1'b1;
      if (sample && state == RD_BYTE)
        rx_sh <= {rx_sh[6:0], sda_in};
      // The final bit was shifted in at Q2, so rx_sh is complete here
      if (bit_end && state == RD_BYTE && bit_cnt == 3'd7) begin
        data_out <= rx_sh;
        rx_valid <= 1'b1;
      end
      if (bit_end && (state == WR_ACK || state == RD_ACK))
        bytes_left <= bytes_left - LW'(1);
      if (bit_end && state == STOP)
        done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_burst_master.sv
// Self-checking bench for i2c_burst_master (default CLK_DIV=4, MAX_BYTES=4,
// so one bit-time is 16 clk cycles). A small slave model watches SCL edges
// after a START and drives scheduled bits onto a wired-AND SDA.
module tb_i2c_burst_master;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       Master_en = 1'b0;
  logic       R_W_en = 1'b0;
  logic [6:0] Mem_Addr = 7'h00;
  logic [2:0] byte_len = 3'd0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req, rx_valid, busy, done, nack, scl, sda_out, sda_oe, sda_in;
  logic [7:0] data_out;
`ifdef I2C_CLK_STRETCH_EN
  logic       scl_in = 1'b1;
`endif

  int passed = 0;
  int checks = 0;

  // clock / reset
  always #5 clk = ~clk;

  i2c_burst_master dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .Master_en (Master_en),
    .R_W_en    (R_W_en),
    .Mem_Addr  (Mem_Addr),
    .byte_len  (byte_len),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .data_out  (data_out),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .done      (done),
    .nack      (nack),
    .scl       (scl),
    .sda_out   (sda_out),
    .sda_oe    (sda_oe),
`ifdef I2C_CLK_STRETCH_EN
    .scl_in    (scl_in),
`endif
    .sda_in    (sda_in)
  );

  // slave model and bus monitor
  logic [63:0] slave_bits = '1;
  logic [6:0]  fall_cnt = 7'd0;
  logic [6:0]  rise_cnt = 7'd0;
  logic        prev_scl = 1'b1;
  logic        prev_msda = 1'b1;
  logic        mst_out [64];
  logic        mst_oe  [64];
  logic [7:0]  rx_log  [64];
  int          tx_total = 0;
  int          rx_total = 0;
  int          done_total = 0;
  int          scl_low_total = 0;
  logic        m_sda, slave_drive;

  assign m_sda       = sda_oe ? sda_out : 1'b1;
  assign slave_drive = (fall_cnt != 7'd0 && fall_cnt <= 7'd64) ?
                       slave_bits[6'(fall_cnt - 7'd1)] : 1'b1;
  assign sda_in      = m_sda & slave_drive;

  always @(posedge clk) begin
    prev_scl  <= scl;
    prev_msda <= m_sda;
    if (tx_req) tx_total <= tx_total + 1;
    if (done) done_total <= done_total + 1;
    if (!scl) scl_low_total <= scl_low_total + 1;
    if (rx_valid) begin
      rx_log[rx_total[5:0]] <= data_out;
      rx_total <= rx_total + 1;
    end
    if (prev_scl && scl && prev_msda && !m_sda) begin
      fall_cnt <= 7'd0;
      rise_cnt <= 7'd0;
    end else begin
      if (prev_scl && !scl && fall_cnt != 7'd127) fall_cnt <= fall_cnt + 7'd1;
      if (!prev_scl && scl && rise_cnt < 7'd64) begin
        mst_out[rise_cnt[5:0]] <= sda_out;
        mst_oe[rise_cnt[5:0]]  <= sda_oe;
        rise_cnt <= rise_cnt + 7'd1;
      end
    end
  end

  // driver: one transfer, returns clk edges from the Master_en edge to done
  // (-1 if done never came). inject_at pulses a second Master_en while busy;
  // stretch_at holds scl_in low for 20 cycles from that edge.
  task automatic run_xfer(input logic rw, input logic [6:0] addr,
                          input logic [2:0] len, input logic [7:0] data,
                          input int inject_at, input int stretch_at,
                          output int cycles);
    @(negedge clk);
    Master_en = 1'b1;
    R_W_en    = rw;
    Mem_Addr  = addr;
    byte_len  = len;
    tx_data   = data;
    @(posedge clk);
    #1;
    Master_en = 1'b0;
    cycles = -1;
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk);
      #1;
      if (n == inject_at) begin
        Master_en = 1'b1;
        R_W_en    = ~rw;
        Mem_Addr  = 7'h7F;
        byte_len  = 3'd2;
      end
      if (n == inject_at + 1) Master_en = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
      if (n == stretch_at) scl_in = 1'b0;
      if (n == stretch_at + 20) scl_in = 1'b1;
`else
      if (n == stretch_at) cycles = -2;
`endif
      if (done) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++; if (scl !== 1'b1) $display("FAIL rst_scl got %b exp 1", scl); else passed++;
    checks++; if (sda_out !== 1'b1) $display("FAIL rst_sda_out got %b exp 1", sda_out); else passed++;
    checks++; if (sda_oe !== 1'b0) $display("FAIL rst_sda_oe got %b exp 0", sda_oe); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL rst_done got %b exp 0", done); else passed++;
    checks++; if (nack !== 1'b0) $display("FAIL rst_nack got %b exp 0", nack); else passed++;
    checks++; if (tx_req !== 1'b0) $display("FAIL rst_tx_req got %b exp 0", tx_req); else passed++;
    checks++; if (rx_valid !== 1'b0) $display("FAIL rst_rx_valid got %b exp 0", rx_valid); else passed++;
    checks++; if (data_out !== 8'h00) $display("FAIL rst_data_out got %h exp 00", data_out); else passed++;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || scl !== 1'b1)
      $display("FAIL post_rst_idle got busy=%b scl=%b exp 0/1", busy, scl); else passed++;
  endtask

  task automatic test_write();
    int cyc, tx0;
    logic [7:0]  got_addr, got_data;
    logic [17:0] got_oe;
    slave_bits = '1;
    slave_bits[8]  = 1'b0;
    slave_bits[17] = 1'b0;
    tx0 = tx_total;
    run_xfer(1'b0, 7'h55, 3'd1, 8'hA5, -10, -10, cyc);
    for (int i = 0; i < 8; i++) begin
      got_addr[7-i] = mst_out[i];
      got_data[7-i] = mst_out[9+i];
    end
    for (int i = 0; i < 18; i++) got_oe[17-i] = mst_oe[i];
    checks++; if (cyc !== 320) $display("FAIL wr_cycles got %0d exp 320", cyc); else passed++;
    checks++; if (got_addr !== 8'hAA) $display("FAIL wr_addr_bits got %h exp aa", got_addr); else passed++;
    checks++; if (got_data !== 8'hA5) $display("FAIL wr_data_bits got %h exp a5", got_data); else passed++;
    checks++; if (got_oe !== {8'hFF, 1'b0, 8'hFF, 1'b0})
      $display("FAIL wr_oe_bits got %b exp 111111110111111110", got_oe); else passed++;
    checks++; if (nack !== 1'b0) $display("FAIL wr_nack got %b exp 0", nack); else passed++;
    checks++; if (tx_total - tx0 !== 1) $display("FAIL wr_tx_req_count got %0d exp 1", tx_total - tx0); else passed++;
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL wr_done_pulse got done=%b busy=%b exp 0/0", done, busy); else passed++;
  endtask

  task automatic test_read();
    int cyc, rx0, tx0;
    logic [7:0] rd_data [3];
    logic [7:0] exp_q [$];
    logic [7:0] e;
    rd_data[0] = 8'h11;
    rd_data[1] = 8'h22;
    rd_data[2] = 8'h33;
    slave_bits = '1;
    slave_bits[8] = 1'b0;
    for (int b = 0; b < 3; b++) begin
      exp_q.push_back(rd_data[b]);
      for (int i = 0; i < 8; i++) slave_bits[9 + 9*b + i] = rd_data[b][7-i];
    end
    rx0 = rx_total;
    tx0 = tx_total;
    run_xfer(1'b1, 7'h03, 3'd3, 8'h00, -10, -10, cyc);
    checks++; if (cyc !== 608) $display("FAIL rd_cycles got %0d exp 608", cyc); else passed++;
    checks++; if (rx_total - rx0 !== 3) $display("FAIL rd_rx_count got %0d exp 3", rx_total - rx0); else passed++;
    for (int b = 0; b < 3; b++) begin
      e = exp_q.pop_front();
      checks++; if (rx_log[6'(rx0 + b)] !== e)
        $display("FAIL rd_byte%0d got %h exp %h", b, rx_log[6'(rx0 + b)], e); else passed++;
    end
    checks++; if ({mst_oe[17], mst_out[17]} !== 2'b10)
      $display("FAIL rd_ack0 got %b%b exp 10", mst_oe[17], mst_out[17]); else passed++;
    checks++; if ({mst_oe[26], mst_out[26]} !== 2'b10)
      $display("FAIL rd_ack1 got %b%b exp 10", mst_oe[26], mst_out[26]); else passed++;
    checks++; if ({mst_oe[35], mst_out[35]} !== 2'b11)
      $display("FAIL rd_nack2 got %b%b exp 11", mst_oe[35], mst_out[35]); else passed++;
    checks++; if (mst_out[7] !== 1'b1) $display("FAIL rd_rw_bit got %b exp 1", mst_out[7]); else passed++;
    checks++; if (nack !== 1'b0 || tx_total !== tx0)
      $display("FAIL rd_status got nack=%b tx_req=%0d exp 0/0", nack, tx_total - tx0); else passed++;
  endtask

  task automatic test_addr_nack();
    int cyc, tx0;
    slave_bits = '1;
    tx0 = tx_total;
    run_xfer(1'b0, 7'h7F, 3'd2, 8'h5A, -10, -10, cyc);
    checks++; if (cyc !== 176) $display("FAIL an_cycles got %0d exp 176", cyc); else passed++;
    checks++; if (nack !== 1'b1) $display("FAIL an_nack got %b exp 1", nack); else passed++;
    checks++; if (tx_total - tx0 !== 0) $display("FAIL an_tx_req got %0d exp 0", tx_total - tx0); else passed++;
    checks++; if (rise_cnt !== 7'd10) $display("FAIL an_scl_rises got %0d exp 10", rise_cnt); else passed++;
    checks++; if ({mst_oe[8], mst_oe[9], mst_out[9]} !== 3'b010)
      $display("FAIL an_stop got %b%b%b exp 010", mst_oe[8], mst_oe[9], mst_out[9]); else passed++;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (nack !== 1'b1) $display("FAIL an_nack_sticky got %b exp 1", nack); else passed++;
  endtask

  task automatic test_busy_and_zero();
    int cyc, tx0, rx0, low0, d0;
    slave_bits = '1;
    slave_bits[8]  = 1'b0;
    slave_bits[17] = 1'b0;
    tx0 = tx_total;
    rx0 = rx_total;
    run_xfer(1'b0, 7'h55, 3'd1, 8'hA5, int'($urandom_range(20, 280)), -10, cyc);
    checks++; if (cyc !== 320) $display("FAIL bz_cycles got %0d exp 320", cyc); else passed++;
    checks++; if (tx_total - tx0 !== 1 || rx_total - rx0 !== 0)
      $display("FAIL bz_traffic got tx=%0d rx=%0d exp 1/0", tx_total - tx0, rx_total - rx0); else passed++;
    checks++; if (nack !== 1'b0) $display("FAIL bz_nack got %b exp 0", nack); else passed++;
    repeat (3) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      low0 = scl_low_total;
      d0   = done_total;
      @(negedge clk);
      Master_en = 1'b1;
      byte_len  = (k == 0) ? 3'd0 : 3'd5;
      @(posedge clk);
      #1;
      Master_en = 1'b0;
      checks++; if (done !== 1'b1 || busy !== 1'b0)
        $display("FAIL bz_len%0d_done got done=%b busy=%b exp 1/0", k, done, busy); else passed++;
      repeat (4) @(posedge clk);
      #1;
      checks++; if (scl_low_total !== low0 || done_total - d0 !== 1)
        $display("FAIL bz_len%0d_quiet got scl_low=%0d done=%0d exp 0/1", k, scl_low_total - low0, done_total - d0);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int cyc, d0, low0, tx0;
    slave_bits = '1;
    slave_bits[8]  = 1'b0;
    slave_bits[17] = 1'b0;
    @(negedge clk);
    Master_en = 1'b1;
    R_W_en    = 1'b0;
    Mem_Addr  = 7'h2C;
    byte_len  = 3'd2;
    tx_data   = 8'h3C;
    @(posedge clk);
    #1;
    Master_en = 1'b0;
    repeat (200) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (scl !== 1'b1 || sda_oe !== 1'b0 || busy !== 1'b0)
      $display("FAIL rm_release got scl=%b oe=%b busy=%b exp 1/0/0", scl, sda_oe, busy); else passed++;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    d0   = done_total;
    low0 = scl_low_total;
    repeat (400) @(posedge clk);
    #1;
    checks++; if (done_total !== d0) $display("FAIL rm_no_done got %0d exp 0", done_total - d0); else passed++;
    checks++; if (scl_low_total !== low0) $display("FAIL rm_no_stop got %0d exp 0", scl_low_total - low0); else passed++;
    tx0 = tx_total;
    run_xfer(1'b0, 7'h55, 3'd1, 8'hA5, -10, -10, cyc);
    checks++; if (cyc !== 320) $display("FAIL rm_retry_cycles got %0d exp 320", cyc); else passed++;
    checks++; if (nack !== 1'b0 || tx_total - tx0 !== 1)
      $display("FAIL rm_retry_status got nack=%b tx=%0d exp 0/1", nack, tx_total - tx0); else passed++;
  endtask

`ifdef I2C_CLK_STRETCH_EN
  task automatic test_stretch();
    int cyc;
    slave_bits = '1;
    slave_bits[8]  = 1'b0;
    slave_bits[17] = 1'b0;
    // ADDR bit 3 is bit-time 4 (cycles 64..79); its Q2 spans cycles 72..75
    run_xfer(1'b0, 7'h55, 3'd1, 8'hA5, -10, 73, cyc);
    checks++; if (cyc !== 340) $display("FAIL st_cycles got %0d exp 340", cyc); else passed++;
    checks++; if (nack !== 1'b0) $display("FAIL st_nack got %b exp 0", nack); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_busy_and_zero();
    test_reset_mid();
`ifdef I2C_CLK_STRETCH_EN
    test_stretch();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
